data_path: RTL and testbench
============================

DATA_PATH -- requirements
Module: data_path

Interface
REQ-001 Port order SHALL be: clk, clr, alu_control, Mdatain, R0out..R15out, MDROut, HIout, LOout, ZHIout, ZLOout, Pout, Cout, Yout, IRen, MARen, MDRen, Read, Yen, Pen, ZHIen, ZLOen, HIen, LOen, R0en..R15en, then outputs BusMuxOut, MAR_q, IR_q.
REQ-002 One clock, clk: input, 1 bit, all registers update on its rising edge.
REQ-003 Reset, clr: input, 1 bit, asynchronous and active-high.
REQ-004 alu_control: input, 5 bits, ALU operation select.
REQ-005 Mdatain: input, 32 bits, memory read data into MDR.
REQ-006 R0out..R15out, MDROut, HIout, LOout, ZHIout, ZLOout, Pout, Cout, Yout: inputs, 1 bit each, bus-drive selects.
REQ-007 R0en..R15en, HIen, LOen, Pen, IRen, MARen, MDRen, Yen, ZHIen, ZLOen: inputs, 1 bit each, register load enables.
REQ-008 Read: input, 1 bit, MDR source select (1 = Mdatain, 0 = bus).
REQ-009 BusMuxOut, MAR_q, IR_q: outputs, 32 bits each, bus value and MAR/IR contents.

Function
REQ-010 Registers SHALL be R0..R15, HI, LO, PC, IR, MAR, MDR, Y (32 bits each) and Z (64 bits: ZHI, ZLO).
REQ-011 Each register SHALL load on the rising clk edge when its enable is 1, and hold otherwise.
REQ-012 R0..R15, HI, LO, PC, IR, MAR and Y SHALL load from BusMuxOut.
REQ-013 MDR SHALL load Mdatain when Read=1 and BusMuxOut when Read=0.
REQ-014 BusMuxOut SHALL be combinational, driven by the asserted out select.
REQ-015 With no out select asserted, BusMuxOut SHALL be 0.
REQ-016 With several out selects asserted, priority SHALL be R0..R15, HI, LO, ZHI, ZLO, PC, MDR, C, Y (first wins).
REQ-017 Cout SHALL drive the constant C = IR[18:0] sign-extended to 32 bits.
REQ-018 The ALU SHALL be combinational with A = Y and B = BusMuxOut, producing a 64-bit result; ZLOen loads result[31:0] into ZLO and ZHIen loads result[63:32] into ZHI.
REQ-019 For non-mul/div operations, result[63:32] SHALL be 0.
REQ-020 ALU codes:
- 00011 add A+B; 00100 sub A-B (mod 2^32)
- 00101 and; 00110 or
- 00111 shr: logical A>>B[4:0]; 01000 shra: arithmetic A>>B[4:0]
- 01001 rol: A rotated left by B[4:0]; 01010 ror: A rotated right by B[4:0]; 01011 shl: A<<B[4:0]
- 01111 mul: signed 64-bit A*B
- 10000 div: signed; low word = quotient, high word = remainder
- 10001 neg: -B; 10010 not: ~B
- 11111 inc: B+1
- any other code: 0
REQ-021 Shift and rotate amounts SHALL use B[4:0] only; an amount of 0 SHALL return A unchanged.
REQ-022 Division by zero SHALL give quotient 0xFFFFFFFF and remainder A.
REQ-023 A register may drive the bus and load in the same cycle; it SHALL capture the pre-edge bus value.

Reset
REQ-024 When clr=1, all registers including Z SHALL clear to 0 immediately, regardless of clk; this also applies mid-operation.
REQ-025 While clr=1, enables SHALL be ignored.

Structure
REQ-026 The ALU opcode constants SHALL live in a shared package, datapath_pkg.
REQ-027 A single parameterised sub-module, reg32 (clk, clr, en, d, q), SHALL be instantiated for every register; Z SHALL use two instances.
REQ-028 The ALU and the bus mux SHALL be combinational logic inside data_path.

Verification
REQ-029 Load R2=0x80000000 and R3=0x00000001 via Mdatain/Read/MDR; Y<-R2; R3out with alu 01001 and ZLOen; ZLOout and R1en -> R1 = 0x00000001.
REQ-030 PC=0; Pout with MARen, alu 11111 and ZLOen -> MAR_q = 0; then ZLOout with Pen -> PC = 1.
REQ-031 Mdatain=0x28918000, Read=1, MDRen; then MDROut with IRen -> IR_q = 0x28918000 and Cout bus = 0x00018000.
REQ-032 Y=0xFFFFFFFF, bus=2, alu 01111, ZHIen and ZLOen -> ZHI = 0xFFFFFFFF, ZLO = 0xFFFFFFFE; div 7/0 -> ZLO = 0xFFFFFFFF, ZHI = 7.
REQ-033 No out select asserted -> BusMuxOut = 0; R1out and R2out together -> R1 value on the bus.
REQ-034 clr pulsed between clock edges during a load sequence -> all registers read 0 before the next edge.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared constants for the 32-bit register/bus datapath: ALU operation codes.
package datapath_pkg;

  typedef enum logic [4:0] {
    AluAdd  = 5'b00011,
    AluSub  = 5'b00100,
    AluAnd  = 5'b00101,
    AluOr   = 5'b00110,
    AluShr  = 5'b00111,
    AluShra = 5'b01000,
    AluRol  = 5'b01001,
    AluRor  = 5'b01010,
    AluShl  = 5'b01011,
    AluMul  = 5'b01111,
    AluDiv  = 5'b10000,
    AluNeg  = 5'b10001,
    AluNot  = 5'b10010,
    AluInc  = 5'b11111
  } alu_op_e;

  localparam int unsigned DataWidth = 32;

endpackage

// File: rtl/reg32.sv
// Load-enabled register with asynchronous active-high clear.
module reg32 #(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/data_path.sv
// Register file, shared bus with fixed-priority mux, and 64-bit-result ALU feeding Z.
module data_path
  import datapath_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic [4:0]  alu_control,
  input  logic [31:0] Mdatain,
  input  logic        R0out,
  input  logic        R1out,
  input  logic        R2out,
  input  logic        R3out,
  input  logic        R4out,
  input  logic        R5out,
  input  logic        R6out,
  input  logic        R7out,
  input  logic        R8out,
  input  logic        R9out,
  input  logic        R10out,
  input  logic        R11out,
  input  logic        R12out,
  input  logic        R13out,
  input  logic        R14out,
  input  logic        R15out,
  input  logic        MDROut,
  input  logic        HIout,
  input  logic        LOout,
  input  logic        ZHIout,
  input  logic        ZLOout,
  input  logic        Pout,
  input  logic        Cout,
  input  logic        Yout,
  input  logic        IRen,
  input  logic        MARen,
  input  logic        MDRen,
  input  logic        Read,
  input  logic        Yen,
  input  logic        Pen,
  input  logic        ZHIen,
  input  logic        ZLOen,
  input  logic        HIen,
  input  logic        LOen,
  input  logic        R0en,
  input  logic        R1en,
  input  logic        R2en,
  input  logic        R3en,
  input  logic        R4en,
  input  logic        R5en,
  input  logic        R6en,
  input  logic        R7en,
  input  logic        R8en,
  input  logic        R9en,
  input  logic        R10en,
  input  logic        R11en,
  input  logic        R12en,
  input  logic        R13en,
  input  logic        R14en,
  input  logic        R15en,
  output logic [31:0] BusMuxOut,
  output logic [31:0] MAR_q,
  output logic [31:0] IR_q
);

  logic [15:0] r_out, r_en;
  logic [31:0] r_q [16];
  logic [31:0] hi_q, lo_q, pc_q, mdr_q, y_q, zhi_q, zlo_q;
  logic [31:0] mdr_d, c_val;
  logic [63:0] alu_result;

  assign r_out = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                  R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};
  assign r_en  = {R15en, R14en, R13en, R12en, R11en, R10en, R9en, R8en,
                  R7en, R6en, R5en, R4en, R3en, R2en, R1en, R0en};

  for (genvar i = 0; i < 16; i++) begin : g_gpr
    reg32 #(.Width(DataWidth)) u_r (
      .clk(clk), .clr(clr), .en(r_en[i]), .d(BusMuxOut), .q(r_q[i])
    );
  end

  assign mdr_d = Read ? Mdatain : BusMuxOut;
  assign c_val = {{13{IR_q[18]}}, IR_q[18:0]};

  reg32 #(.Width(DataWidth)) u_hi  (.clk(clk), .clr(clr), .en(HIen),  .d(BusMuxOut), .q(hi_q));
  reg32 #(.Width(DataWidth)) u_lo  (.clk(clk), .clr(clr), .en(LOen),  .d(BusMuxOut), .q(lo_q));
  reg32 #(.Width(DataWidth)) u_pc  (.clk(clk), .clr(clr), .en(Pen),   .d(BusMuxOut), .q(pc_q));
  reg32 #(.Width(DataWidth)) u_ir  (.clk(clk), .clr(clr), .en(IRen),  .d(BusMuxOut), .q(IR_q));
  reg32 #(.Width(DataWidth)) u_mar (.clk(clk), .clr(clr), .en(MARen), .d(BusMuxOut), .q(MAR_q));
  reg32 #(.Width(DataWidth)) u_mdr (.clk(clk), .clr(clr), .en(MDRen), .d(mdr_d),     .q(mdr_q));
  reg32 #(.Width(DataWidth)) u_y   (.clk(clk), .clr(clr), .en(Yen),   .d(BusMuxOut), .q(y_q));
  reg32 #(.Width(DataWidth)) u_zhi (.clk(clk), .clr(clr), .en(ZHIen),
                                    .d(alu_result[63:32]), .q(zhi_q));
  reg32 #(.Width(DataWidth)) u_zlo (.clk(clk), .clr(clr), .en(ZLOen),
                                    .d(alu_result[31:0]), .q(zlo_q));

  // Lowest-priority source assigned first so that later assignments win.
  always_comb begin
    BusMuxOut = '0;
    if (Yout)   BusMuxOut = y_q;
    if (Cout)   BusMuxOut = c_val;
    if (MDROut) BusMuxOut = mdr_q;
    if (Pout)   BusMuxOut = pc_q;
    if (ZLOout) BusMuxOut = zlo_q;
    if (ZHIout) BusMuxOut = zhi_q;
    if (LOout)  BusMuxOut = lo_q;
    if (HIout)  BusMuxOut = hi_q;
    for (int i = 15; i >= 0; i--) begin
      if (r_out[i]) BusMuxOut = r_q[i];
    end
  end

  logic [31:0]        alu_a, alu_b, quot, rem;
  logic [4:0]         sh;
  logic [63:0]        rot_l, rot_r;
  logic signed [63:0] prod;

  assign alu_a = y_q;
  assign alu_b = BusMuxOut;
  assign sh    = alu_b[4:0];
  assign rot_l = {alu_a, alu_a} << sh;
  assign rot_r = {alu_a, alu_a} >> sh;
  assign prod  = $signed({{32{alu_a[31]}}, alu_a}) * $signed({{32{alu_b[31]}}, alu_b});

  // Guard the two cases where native signed division is undefined or overflows.
  always_comb begin
    quot = '0;
    rem  = '0;
    if (alu_b == '0) begin
      quot = '1;
      rem  = alu_a;
    end else if (alu_a == 32'h8000_0000 && alu_b == '1) begin
      quot = alu_a;
      rem  = '0;
    end else begin
      quot = $signed(alu_a) / $signed(alu_b);
      rem  = $signed(alu_a) % $signed(alu_b);
    end
  end

  always_comb begin
    alu_result = '0;
    case (alu_control)
      AluAdd:  alu_result[31:0] = alu_a + alu_b;
      AluSub:  alu_result[31:0] = alu_a - alu_b;
      AluAnd:  alu_result[31:0] = alu_a & alu_b;
      AluOr:   alu_result[31:0] = alu_a | alu_b;
      AluShr:  alu_result[31:0] = alu_a >> sh;
      AluShra: alu_result[31:0] = $signed(alu_a) >>> sh;
      AluRol:  alu_result[31:0] = rot_l[63:32];
      AluRor:  alu_result[31:0] = rot_r[31:0];
      AluShl:  alu_result[31:0] = alu_a << sh;
      AluMul:  alu_result       = prod;
      AluDiv:  alu_result       = {rem, quot};
      AluNeg:  alu_result[31:0] = -alu_b;
      AluNot:  alu_result[31:0] = ~alu_b;
      AluInc:  alu_result[31:0] = alu_b + 32'd1;
      default: alu_result       = '0;
    endcase
  end

endmodule

// File: tb/tb_data_path.sv
// Randomized bench for data_path against an arithmetic reference model of the datapath.
module tb_data_path;

  logic        clk, clr, rd;
  logic [4:0]  alu;
  logic [31:0] mdat;
  logic [23:0] sel;  // 0-15 R, 16 HI, 17 LO, 18 ZHI, 19 ZLO, 20 PC, 21 MDR, 22 C, 23 Y
  logic [24:0] en;   // 0-15 R, 16 HI, 17 LO, 18 PC, 19 IR, 20 MAR, 21 MDR, 22 Y, 23 ZHI, 24 ZLO
  logic [31:0] BusMuxOut, MAR_q, IR_q;

  int n_cmp = 0;
  int n_err = 0;

  bit [31:0] m_r [16];
  bit [31:0] m_hi, m_lo, m_pc, m_ir, m_mar, m_mdr, m_y, m_zhi, m_zlo;

  data_path dut (
    .clk(clk), .clr(clr), .alu_control(alu), .Mdatain(mdat),
    .R0out(sel[0]), .R1out(sel[1]), .R2out(sel[2]), .R3out(sel[3]),
    .R4out(sel[4]), .R5out(sel[5]), .R6out(sel[6]), .R7out(sel[7]),
    .R8out(sel[8]), .R9out(sel[9]), .R10out(sel[10]), .R11out(sel[11]),
    .R12out(sel[12]), .R13out(sel[13]), .R14out(sel[14]), .R15out(sel[15]),
    .MDROut(sel[21]), .HIout(sel[16]), .LOout(sel[17]), .ZHIout(sel[18]),
    .ZLOout(sel[19]), .Pout(sel[20]), .Cout(sel[22]), .Yout(sel[23]),
    .IRen(en[19]), .MARen(en[20]), .MDRen(en[21]), .Read(rd), .Yen(en[22]),
    .Pen(en[18]), .ZHIen(en[23]), .ZLOen(en[24]), .HIen(en[16]), .LOen(en[17]),
    .R0en(en[0]), .R1en(en[1]), .R2en(en[2]), .R3en(en[3]),
    .R4en(en[4]), .R5en(en[5]), .R6en(en[6]), .R7en(en[7]),
    .R8en(en[8]), .R9en(en[9]), .R10en(en[10]), .R11en(en[11]),
    .R12en(en[12]), .R13en(en[13]), .R14en(en[14]), .R15en(en[15]),
    .BusMuxOut(BusMuxOut), .MAR_q(MAR_q), .IR_q(IR_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h, expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit [31:0] src_val(input int i);
    bit [31:0] c;
    c = 32'(signed'(m_ir[18:0]));
    if (i < 16) return m_r[i];
    case (i)
      16: return m_hi;
      17: return m_lo;
      18: return m_zhi;
      19: return m_zlo;
      20: return m_pc;
      21: return m_mdr;
      22: return c;
      default: return m_y;
    endcase
  endfunction

  // Sources listed in priority order; the first asserted one wins.
  function automatic bit [31:0] ref_bus(input logic [23:0] s);
    for (int i = 0; i < 24; i++) begin
      if (s[i]) return src_val(i);
    end
    return 32'h0;
  endfunction

  function automatic bit [63:0] ref_alu(input bit [4:0] op, input bit [31:0] a, input bit [31:0] b);
    bit [31:0] t;
    longint la, lb, q, r;
    int n;
    n  = int'(b[4:0]);
    la = $signed(a);
    lb = $signed(b);
    t  = a;
    case (op)
      5'b00011: t = a + b;
      5'b00100: t = a - b;
      5'b00101: t = a & b;
      5'b00110: t = a | b;
      5'b00111: repeat (n) t = t / 2;
      5'b01000: begin
        repeat (n) la = (la - (la & 1)) / 2;  // floor division by two
        t = la[31:0];
      end
      5'b01001: repeat (n) t = {t[30:0], t[31]};
      5'b01010: repeat (n) t = {t[0], t[31:1]};
      5'b01011: repeat (n) t = t * 2;
      5'b01111: begin
        q = la * lb;
        return q;
      end
      5'b10000: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = la / lb;
        r = la % lb;
        return {r[31:0], q[31:0]};
      end
      5'b10001: t = 32'h0 - b;
      5'b10010: t = ~b;
      5'b11111: t = b + 1;
      default:  t = 32'h0;
    endcase
    return {32'h0, t};
  endfunction

  task automatic model_reset();
    foreach (m_r[i]) m_r[i] = 0;
    {m_hi, m_lo, m_pc, m_ir, m_mar, m_mdr, m_y, m_zhi, m_zlo} = '0;
  endtask

  task automatic step(input logic [23:0] s, input logic [24:0] e, input logic [4:0] op,
                      input logic [31:0] md, input logic r);
    bit [31:0] b;
    bit [63:0] z;
    @(negedge clk);
    sel = s; en = e; alu = op; mdat = md; rd = r;
    #1;
    b = ref_bus(s);
    z = ref_alu(op, m_y, b);
    check_eq("bus", BusMuxOut, b);
    check_eq("mar", MAR_q, m_mar);
    check_eq("ir", IR_q, m_ir);
    @(posedge clk);
    for (int i = 0; i < 16; i++) if (e[i]) m_r[i] = b;
    if (e[16]) m_hi  = b;
    if (e[17]) m_lo  = b;
    if (e[18]) m_pc  = b;
    if (e[19]) m_ir  = b;
    if (e[20]) m_mar = b;
    if (e[21]) m_mdr = r ? md : b;
    if (e[22]) m_y   = b;
    if (e[23]) m_zhi = z[63:32];
    if (e[24]) m_zlo = z[31:0];
  endtask

  task automatic peek(input string tag, input logic [23:0] s, input logic [31:0] exp);
    @(negedge clk);
    sel = s; en = '0;
    #1;
    check_eq(tag, BusMuxOut, exp);
  endtask

  task automatic load_via_mdr(input int dst_en, input logic [31:0] v);
    step(24'h0, 25'(1) << 21, 5'd0, v, 1'b1);
    step(24'(1) << 21, 25'(1) << dst_en, 5'd0, 32'h0, 1'b0);
  endtask

  task automatic clr_pulse();
    @(negedge clk);
    en = '0;
    @(posedge clk);
    #2 clr = 1'b1;
    #1;
    check_eq("clr_mar", MAR_q, 32'h0);
    check_eq("clr_ir", IR_q, 32'h0);
    check_eq("clr_bus", BusMuxOut, 32'h0);
    model_reset();
    #1 clr = 1'b0;
  endtask

  bit [4:0] ops [15] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000,
                         5'b01001, 5'b01010, 5'b01011, 5'b01111, 5'b10000, 5'b10001,
                         5'b10010, 5'b11111, 5'b00000};

  localparam int SelHi = 16, SelLo = 17, SelZhi = 18, SelZlo = 19, SelPc = 20, SelMdr = 21;
  localparam int SelC = 22, SelY = 23;
  localparam int EnPc = 18, EnIr = 19, EnMar = 20, EnMdr = 21, EnY = 22, EnZhi = 23, EnZlo = 24;

  initial begin
    logic [23:0] s;
    logic [24:0] e;
    logic [4:0]  op;
    logic [31:0] md;
    int          k;

    clr = 1'b1; sel = '0; en = '0; alu = '0; mdat = '0; rd = 1'b0;
    model_reset();
    #3;
    for (int i = 0; i < 24; i++) begin
      sel = 24'(1) << i;
      #1;
      check_eq("rst_src", BusMuxOut, 32'h0);
    end
    check_eq("rst_mar", MAR_q, 32'h0);
    check_eq("rst_ir", IR_q, 32'h0);

    // Enables must be ignored while clear is held.
    sel = '0; en = '1; rd = 1'b1; mdat = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    check_eq("clr_hold_mar", MAR_q, 32'h0);
    @(negedge clk);
    clr = 1'b0; en = '0; rd = 1'b0;
    peek("clr_hold_mdr", 24'(1) << SelMdr, 32'h0);

    // Rotate-left of 0x80000000 by 1.
    load_via_mdr(2, 32'h8000_0000);
    load_via_mdr(3, 32'h0000_0001);
    step(24'(1) << 2, 25'(1) << EnY, 5'd0, 32'h0, 1'b0);
    step(24'(1) << 3, 25'(1) << EnZlo, 5'b01001, 32'h0, 1'b0);
    step(24'(1) << SelZlo, 25'(1) << 1, 5'd0, 32'h0, 1'b0);
    peek("rol_r1", 24'(1) << 1, 32'h0000_0001);

    // PC increment through Z.
    step(24'(1) << SelPc, (25'(1) << EnMar) | (25'(1) << EnZlo), 5'b11111, 32'h0, 1'b0);
    check_eq("pc_mar", MAR_q, 32'h0);
    step(24'(1) << SelZlo, 25'(1) << EnPc, 5'd0, 32'h0, 1'b0);
    peek("pc_inc", 24'(1) << SelPc, 32'h0000_0001);

    // Instruction fetch and C constant.
    step(24'h0, 25'(1) << EnMdr, 5'd0, 32'h2891_8000, 1'b1);
    step(24'(1) << SelMdr, 25'(1) << EnIr, 5'd0, 32'h0, 1'b0);
    peek("c_const", 24'(1) << SelC, 32'h0001_8000);
    check_eq("ir_q", IR_q, 32'h2891_8000);

    // Signed multiply and divide by zero.
    load_via_mdr(EnY, 32'hFFFF_FFFF);
    load_via_mdr(4, 32'h0000_0002);
    step(24'(1) << 4, (25'(1) << EnZhi) | (25'(1) << EnZlo), 5'b01111, 32'h0, 1'b0);
    peek("mul_zhi", 24'(1) << SelZhi, 32'hFFFF_FFFF);
    peek("mul_zlo", 24'(1) << SelZlo, 32'hFFFF_FFFE);
    load_via_mdr(EnY, 32'h0000_0007);
    step(24'(1) << 5, (25'(1) << EnZhi) | (25'(1) << EnZlo), 5'b10000, 32'h0, 1'b0);
    peek("div0_zlo", 24'(1) << SelZlo, 32'hFFFF_FFFF);
    peek("div0_zhi", 24'(1) << SelZhi, 32'h0000_0007);

    // Empty bus and priority.
    peek("bus_none", 24'h0, 32'h0);
    peek("bus_prio", 24'h6, 32'h0000_0001);

    // Clear mid-sequence, then confirm every source reads zero.
    step(24'(1) << 1, (25'(1) << 6) | (25'(1) << EnMar), 5'd0, 32'h0, 1'b0);
    clr_pulse();
    for (int i = 0; i < 24; i++) peek("post_clr", 24'(1) << i, 32'h0);

    for (int it = 0; it < 500; it++) begin
      k = $urandom_range(0, 99);
      if (k < 70)      s = 24'(1) << $urandom_range(0, 23);
      else if (k < 85) s = '0;
      else             s = 24'($urandom & $urandom);
      e  = 25'($urandom & $urandom & $urandom);
      op = ($urandom_range(0, 9) == 0) ? 5'($urandom) : ops[$urandom_range(0, 14)];
      k  = $urandom_range(0, 3);
      if (k == 0)      md = $urandom_range(0, 40);
      else if (k == 1) md = 32'h8000_0000 | $urandom_range(0, 3);
      else             md = $urandom;
      step(s, e, op, md, 1'($urandom));
      if ($urandom_range(0, 59) == 0) clr_pulse();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
